// File: rtl/frame_pkg.sv
// Link framing constants shared by the transmit stuffer, receive destuffer and core.
package frame_pkg;

    localparam logic [7:0] FRAME_START = 8'h06;
    localparam logic [7:0] FRAME_END   = 8'h07;
    localparam logic [7:0] ESC_VAL     = 8'h14;
    localparam logic [7:0] ESC_XOR     = 8'h20;

    typedef enum logic [7:0] {
        CONFIRM_ERROR       = 8'h04,
        CONFIRM_OKAY        = 8'h05,
        CONFIRM_FATAL_ERROR = 8'h08
    } confirm_code_e;

    // state | meaning
    // IDLE  | waiting for frame_in_valid
    // START | presenting FRAME_START
    // DATA  | presenting payload byte, or ESC_VAL if it must be stuffed
    // ESC   | presenting the xor-ed payload byte after ESC_VAL
    // END   | presenting FRAME_END
    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_START = 5'b00010,
        ST_DATA  = 5'b00100,
        ST_ESC   = 5'b01000,
        ST_END   = 5'b10000
    } tx_state_e;

    function automatic logic is_special(input logic [7:0] b);
        return (b == FRAME_START) || (b == FRAME_END) || (b == ESC_VAL);
    endfunction

endpackage

// File: rtl/byte_escape.sv
// Classifies one byte: flags collisions with framing values and gives its escaped form.
module byte_escape
    import frame_pkg::*;
(
    input  logic [7:0] b,
    output logic       needs_esc,
    output logic [7:0] escaped
);

    assign needs_esc = is_special(b);
    assign escaped   = b ^ ESC_XOR;

endmodule

// File: rtl/frame_stuffer_tx.sv
// Serializes one parallel frame into a flagged, byte-stuffed stream on a valid/ready byte port.
module frame_stuffer_tx
    import frame_pkg::*;
#(
    parameter int FRAME_BYTES = 87,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [0:FRAME_BYTES*8-1] frame_in,
    input  logic                     frame_in_valid,
    output logic                     busy,
    output logic [7:0]               tx_byte,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     done,
    output logic [7:0]               esc_count,
    output logic [CNT_W-1:0]         frames_sent
);

    localparam int IDX_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    tx_state_e                state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [0:FRAME_BYTES*8-1] shadow_q;
    logic [7:0]               tally_q, tally_d;
    logic [7:0]               esc_count_q, esc_count_d;
    logic [CNT_W-1:0]         frames_q, frames_d;
    logic                     done_q, done_d;

    logic [IDX_W+2:0] byte_base;
    logic [7:0]       cur_byte;
    logic             needs_esc;
    logic [7:0]       escaped;
    logic             accept;
    logic             hs;

    assign byte_base = {idx_q, 3'b000};
    assign cur_byte  = shadow_q[byte_base +: 8];

    byte_escape u_byte_escape (
        .b         (cur_byte),
        .needs_esc (needs_esc),
        .escaped   (escaped)
    );

    assign tx_valid    = (state_q != ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign hs          = tx_valid && tx_ready;
    assign accept      = (state_q == ST_IDLE) && frame_in_valid;
    assign done        = done_q;
    assign esc_count   = esc_count_q;
    assign frames_sent = frames_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tally_d     = tally_q;
        esc_count_d = esc_count_q;
        frames_d    = frames_q;
        done_d      = 1'b0;
        tx_byte     = 8'h00;

        unique case (state_q)
            ST_IDLE: begin
                if (frame_in_valid) begin
                    state_d = ST_START;
                    tally_d = 8'h00;
                end
            end
            ST_START: begin
                tx_byte = FRAME_START;
                if (hs) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                tx_byte = needs_esc ? ESC_VAL : cur_byte;
                if (hs) begin
                    if (needs_esc) begin
                        state_d = ST_ESC;
                        if (tally_q != 8'hFF) tally_d = tally_q + 8'd1;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = ST_END;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_ESC: begin
                tx_byte = escaped;
                if (hs) begin
                    if (idx_q == LAST_IDX) state_d = ST_END;
                    else begin
                        state_d = ST_DATA;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            ST_END: begin
                tx_byte = FRAME_END;
                if (hs) begin
                    state_d     = ST_IDLE;
                    done_d      = 1'b1;
                    frames_d    = frames_q + 1'b1;
                    esc_count_d = tally_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            tally_q     <= 8'h00;
            esc_count_q <= 8'h00;
            frames_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tally_q     <= tally_d;
            esc_count_q <= esc_count_d;
            frames_q    <= frames_d;
            done_q      <= done_d;
        end
    end

    // Payload is only read while busy, so the shadow needs no reset.
    always_ff @(posedge clk) begin
        if (accept) shadow_q <= frame_in;
    end

endmodule

// File: tb/tb_frame_stuffer_tx.sv
// Randomized bench for frame_stuffer_tx: a small (4-byte) and a default (87-byte) instance vs a stream model.
module tb_frame_stuffer_tx;

    localparam int FA = 4;
    localparam int FB = 87;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic tx_ready;

    logic [0:FA*8-1] fin_a;
    logic            fv_a, busy_a, val_a, done_a;
    logic [7:0]      byte_a, esc_a;
    logic [15:0]     fs_a;

    logic [0:FB*8-1] fin_b;
    logic            fv_b, busy_b, val_b, done_b;
    logic [7:0]      byte_b, esc_b;
    logic [15:0]     fs_b;

    frame_stuffer_tx #(.FRAME_BYTES(FA), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .frame_in(fin_a), .frame_in_valid(fv_a),
        .busy(busy_a), .tx_byte(byte_a), .tx_valid(val_a), .tx_ready(tx_ready),
        .done(done_a), .esc_count(esc_a), .frames_sent(fs_a)
    );

    frame_stuffer_tx dut_b (
        .clk(clk), .rst(rst), .frame_in(fin_b), .frame_in_valid(fv_b),
        .busy(busy_b), .tx_byte(byte_b), .tx_valid(val_b), .tx_ready(tx_ready),
        .done(done_b), .esc_count(esc_b), .frames_sent(fs_b)
    );

    bit sel;  // 0 = small instance, 1 = default instance
    logic        m_valid, m_busy, m_done;
    logic [7:0]  m_byte, m_esc;
    logic [15:0] m_fs;
    assign m_valid = sel ? val_b  : val_a;
    assign m_busy  = sel ? busy_b : busy_a;
    assign m_done  = sel ? done_b : done_a;
    assign m_byte  = sel ? byte_b : byte_a;
    assign m_esc   = sel ? esc_b  : esc_a;
    assign m_fs    = sel ? fs_b   : fs_a;

    int checks = 0;
    int failures = 0;

    logic [7:0] frm[$];
    logic [7:0] chain_frm[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         exp_esc;
    int         exp_fs[2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit special(input logic [7:0] b);
        return (b == 8'h06) || (b == 8'h07) || (b == 8'h14);
    endfunction

    // Expected wire image of frm: flag, stuffed payload, flag.
    task automatic model();
        exp_q.delete();
        exp_esc = 0;
        exp_q.push_back(8'h06);
        foreach (frm[i]) begin
            if (special(frm[i])) begin
                exp_q.push_back(8'h14);
                exp_q.push_back(frm[i] ^ 8'h20);
                exp_esc++;
            end else begin
                exp_q.push_back(frm[i]);
            end
        end
        exp_q.push_back(8'h07);
        if (exp_esc > 255) exp_esc = 255;
    endtask

    task automatic rand_frame(input int n, input int pct);
        logic [7:0] sp[3];
        sp[0] = 8'h06; sp[1] = 8'h07; sp[2] = 8'h14;
        frm.delete();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 99) < pct) frm.push_back(sp[$urandom_range(0, 2)]);
            else frm.push_back(8'($urandom));
        end
    endtask

    task automatic load(input logic [7:0] fr[$]);
        if (!sel) for (int k = 0; k < FA; k++) fin_a[8*k +: 8] = fr[k];
        else      for (int k = 0; k < FB; k++) fin_b[8*k +: 8] = fr[k];
    endtask

    task automatic request();
        @(negedge clk);
        load(frm);
        if (sel) fv_b = 1'b1; else fv_a = 1'b1;
    endtask

    task automatic xfer(input bit thr, input int abort_after, input bit poke, input bit chain);
        int cyc = 0, n = 0, gaps = 0, last_hs = -10;
        bit started = 0, stall = 0, saw_done = 0, rdy;
        logic [7:0] pb = 8'h00;
        got_q.delete();
        while (cyc < 3000) begin
            @(negedge clk);
            fv_a = 1'b0; fv_b = 1'b0;
            cyc++;
            if (cyc == 1) begin
                check_val("first_valid", m_valid, 1);
                check_val("first_byte", m_byte, 8'h06);
                check_val("first_busy", m_busy, 1);
            end
            if (chain && cyc == 2) load(chain_frm);
            if (m_done) begin
                saw_done = 1;
                check_val("done_latency", cyc - last_hs, 1);
                check_val("done_busy", m_busy, 0);
                check_val("done_valid", m_valid, 0);
                if (chain) begin
                    if (sel) fv_b = 1'b1; else fv_a = 1'b1;
                end
                break;
            end
            if (stall) begin
                check_val("hold_valid", m_valid, 1);
                check_val("hold_byte", m_byte, pb);
            end
            if (m_valid) started = 1;
            else if (started) gaps++;
            if (poke && cyc == 3) begin
                if (sel) begin
                    for (int k = 0; k < FB; k++) fin_b[8*k +: 8] = 8'($urandom);
                    fv_b = 1'b1;
                end else begin
                    for (int k = 0; k < FA; k++) fin_a[8*k +: 8] = 8'($urandom);
                    fv_a = 1'b1;
                end
            end
            rdy = thr ? 1'($urandom_range(0, 1)) : 1'b1;
            tx_ready = rdy;
            if (m_valid && rdy) begin
                got_q.push_back(m_byte);
                n++;
                last_hs = cyc;
            end
            stall = m_valid && !rdy;
            pb = m_byte;
            if (abort_after != 0 && n == abort_after) break;
        end
        check_val("no_valid_gap", gaps, 0);
        if (abort_after == 0) begin
            check_val("done_seen", saw_done, 1);
            if (saw_done) exp_fs[sel]++;
            if (!chain) begin
                @(negedge clk);
                check_val("done_one_cycle", m_done, 0);
            end
        end
    endtask

    task automatic cmp_stream();
        check_val("stream_len", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check_val($sformatf("stream_byte%0d", i), got_q[i], exp_q[i]);
    endtask

    task automatic cmp_stats();
        check_val("esc_count", m_esc, exp_esc);
        check_val("frames_sent", m_fs, exp_fs[sel] & 16'hFFFF);
    endtask

    initial begin
        rst = 1'b1; tx_ready = 1'b0; fv_a = 1'b0; fv_b = 1'b0;
        fin_a = '0; fin_b = '0; sel = 0;
        exp_fs[0] = 0; exp_fs[1] = 0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy_a, 0);
        check_val("rst_valid", val_a, 0);
        check_val("rst_byte", byte_a, 8'h00);
        check_val("rst_done", done_a, 0);
        check_val("rst_esc", esc_a, 0);
        check_val("rst_frames", fs_a, 0);
        check_val("rst_b_valid", val_b, 0);
        check_val("rst_b_frames", fs_b, 0);
        rst = 1'b0;

        // reset after the third transferred byte
        rand_frame(FA, 30);
        model();
        request();
        xfer(0, 3, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_valid", m_valid, 0);
        check_val("abort_busy", m_busy, 0);
        check_val("abort_frames", m_fs, 0);
        check_val("abort_len", got_q.size(), 3);
        for (int i = 0; i < 3; i++) check_val("abort_byte", got_q[i], exp_q[i]);
        repeat (3) begin
            @(negedge clk);
            check_val("abort_no_end", m_valid, 0);
        end

        frm = {8'h01, 8'h02, 8'h03, 8'h04};
        model();
        request();
        xfer(0, 0, 0, 0);
        cmp_stream();
        cmp_stats();

        frm = {8'h06, 8'h07, 8'h14, 8'h05};
        model();
        request();
        xfer(0, 0, 0, 0);
        cmp_stream();
        cmp_stats();

        for (int it = 0; it < 20; it++) begin
            rand_frame(FA, 35);
            model();
            request();
            xfer(1, 0, 0, 0);
            cmp_stream();
            cmp_stats();
        end

        // request while busy is ignored
        rand_frame(FA, 25);
        model();
        request();
        xfer(1, 0, 1, 0);
        cmp_stream();
        cmp_stats();

        // request in the done cycle starts the next frame immediately
        rand_frame(FA, 25);
        chain_frm = frm;
        rand_frame(FA, 25);
        model();
        request();
        xfer(0, 0, 0, 1);
        cmp_stream();
        cmp_stats();
        frm = chain_frm;
        model();
        xfer(1, 0, 0, 0);
        cmp_stream();
        cmp_stats();

        sel = 1;
        frm.delete();
        for (int i = 0; i < FB; i++) frm.push_back(8'h14);
        model();
        request();
        xfer(0, 0, 0, 0);
        cmp_stream();
        check_val("all14_len", got_q.size(), 176);
        cmp_stats();

        for (int it = 0; it < 2; it++) begin
            rand_frame(FB, 20);
            model();
            request();
            xfer(1, 0, 0, 0);
            cmp_stream();
            cmp_stats();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_stuffer_tx.md
Name: frame_stuffer_tx

Overview:
- Transmit-side framer for the serial link.
- Takes one parallel frame, for example the Fout_j or Fout_t frame from the core. It emits the frame byte-by-byte over a valid/ready byte interface toward the UART transmitter.
- Wraps the frame in FRAME_START/FRAME_END flags and byte-stuffs payload bytes that collide with the flag or escape values.
- It is the encoder matching the receive-side destuffer that feeds Fin_j/Fin_t.

Parameters:
- FRAME_BYTES, 87, number of payload bytes per frame: preamble 7 + nonce 12 + data 64 + crc 4.
- CNT_W, 16, width of the frames-sent counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- frame_in  in  [0:FRAME_BYTES*8-1]  parallel frame; byte k = frame_in[8k:8k+7]; byte 0 is sent first.
- frame_in_valid  in  1  single-cycle request to send frame_in.
- busy  out  1  high while a frame is being transmitted; requests are ignored while high.
- tx_byte  out  8  current output byte.
- tx_valid  out  1  tx_byte is valid.
- tx_ready  in  1  downstream accepts tx_byte at a posedge where tx_valid && tx_ready.
- done  out  1  one-cycle pulse after the FRAME_END byte is transferred.
- esc_count  out  8  number of escapes inserted in the last completed frame; saturates at 255.
- frames_sent  out  CNT_W  count of completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset values: busy=0, tx_byte=8'h00, tx_valid=0, done=0, esc_count=0, frames_sent=0, state=IDLE, byte index=0.
- Reset mid-frame: abort immediately. No FRAME_END is emitted and frames_sent is not incremented.
- Accept: in IDLE, frame_in_valid=1 at edge N latches frame_in into a shadow register.
  - busy=1 from N+1.
  - tx_valid=1 with tx_byte=FRAME_START (8'h06) from N+1.
  - frame_in_valid outside IDLE is ignored. No queuing.
- Output hold: tx_byte and tx_valid remain stable until the handshake (tx_valid && tx_ready at a posedge). The next byte is presented in the following cycle.
  - With tx_ready held high, one byte is transferred per cycle.
  - tx_valid never drops between the START and END bytes of a frame.
- States:
  - IDLE -> START on accept.
  - START -> DATA on handshake; index=0.
  - DATA: present byte b = shadow[index].
    - If b is 8'h06, 8'h07 or 8'h14: present ESC_VAL 8'h14. On handshake -> ESC with the held byte b.
    - Otherwise present b. On handshake: index+1, or -> END after index == FRAME_BYTES-1.
  - ESC: present b ^ ESC_XOR (8'h20). On handshake: advance index exactly as DATA does.
  - END: present FRAME_END 8'h07. On handshake -> IDLE.
    - Same edge: tx_valid=0, busy=0, done=1 for one cycle, frames_sent+1, esc_count updated from its running tally.
- A new frame_in_valid in the cycle done is high is accepted, since the block is already in IDLE. Back-to-back frames therefore have exactly one idle cycle between them.
- The running escape tally is cleared on accept and saturates at 255.
- Stuffed length equals FRAME_BYTES + 2 + number of escapes; the maximum is 2*FRAME_BYTES + 2.
- tx_ready is don't-care while tx_valid=0.
- The escaped value b^0x20 is never itself re-escaped, because 0x26, 0x27 and 0x34 are not special.

Decomposition:
- Shared package (frame_pkg), also used by the receive destuffer and the core:
  - FRAME_START=8'h06, FRAME_END=8'h07, ESC_VAL=8'h14, ESC_XOR=8'h20.
  - Frame-type and confirm-code constants (OKAY 8'h05, ERROR 8'h04, FATAL_ERROR 8'h08).
  - One-hot state encoding for this block.
- One natural sub-module: byte_escape, a combinational classifier. Input b; outputs needs_esc and escaped = b^ESC_XOR. It is shared with the destuffer for the inverse check.
- Byte selection from the shadow register uses an indexed part-select; no separate module.

Test Plan:
- No specials, tx_ready held 1, FRAME_BYTES=4 (override), frame 0x01020304:
  - Stream is 06 01 02 03 04 07 on consecutive cycles starting at N+1.
  - done pulses one cycle after the 07 transfer; esc_count=0; frames_sent=1.
- All-special frame 0x06071405:
  - Stream is 06 14 26 14 27 14 34 05 07; esc_count=3.
- Backpressure: toggle tx_ready 1,0,0,1 randomly.
  - tx_byte/tx_valid stay stable while tx_ready=0.
  - Byte sequence is identical to the unthrottled run; no byte is duplicated or dropped.
- frame_in_valid pulsed while busy:
  - Ignored; the current frame completes unchanged.
  - A request in the done cycle starts a new frame with 06 on the next cycle.
- rst asserted after the 3rd transferred byte:
  - Next cycle tx_valid=0, busy=0, frames_sent unchanged, no 07 emitted.
  - A subsequent frame transmits correctly from 06.
- Default FRAME_BYTES=87, frame of all 8'h14:
  - 176 bytes transferred (06, 87 × {14 34}, 07); esc_count=87.
  - frames_sent wraps from 16'hFFFF to 0 when preloaded via a sequence of frames in a long-run test.
